// File: rtl/sccb_pkg.sv
// Shared types and helpers for the SCCB write-master arbiter.
`default_nettype none

package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_ACK       = 3'd4,
    ST_GAP       = 3'd5
  } sccb_arb_state_t;

  localparam int REQ_CFG = 0;
  localparam int REQ_USR = 1;

  function automatic int timeout_cycles(input int clk_f, input int timeout_us);
    return (clk_f / 1_000_000) * timeout_us;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sccb_arbiter.sv
// Two-requester arbiter in front of a single SCCB/I2C write master, with
// fixed CFG priority, start/busy watchdogs and an enforced bus-free gap.
`default_nettype none

module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter int CLK_F      = 100_000_000,
  parameter int TIMEOUT_US = 1000,
  parameter int START_WAIT = 8,
  parameter int GAP_CYCLES = 100
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_cfg_req,
  input  logic [7:0] i_cfg_addr,
  input  logic [7:0] i_cfg_data,
  output logic       o_cfg_ack,
  input  logic       i_cfg_done,
  input  logic       i_usr_req,
  input  logic [7:0] i_usr_addr,
  input  logic [7:0] i_usr_data,
  output logic       o_usr_ack,
  input  logic       i_i2c_ready,
  output logic       o_i2c_start,
  output logic [7:0] o_i2c_addr,
  output logic [7:0] o_i2c_data,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_err
);

  localparam int TIMEOUT_CYCLES = timeout_cycles(CLK_F, TIMEOUT_US);
  localparam int MAX_CNT        = max3(TIMEOUT_CYCLES, GAP_CYCLES, START_WAIT);
  localparam int CNT_W          = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_WAIT);
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_CYCLES - 1);

  sccb_arb_state_t  state;
  sccb_arb_state_t  state_next;
  logic [CNT_W-1:0] cnt;
  logic             take_cfg;
  logic             take_usr;
  logic             start_to;
  logic             busy_to;

  assign take_cfg = i_i2c_ready & i_cfg_req;
  assign take_usr = i_i2c_ready & ~i_cfg_req & i_usr_req & i_cfg_done;
  assign start_to = (state == ST_WAIT_LOW)  &  i_i2c_ready & (cnt >= START_LIM);
  assign busy_to  = (state == ST_WAIT_HIGH) & ~i_i2c_ready & (cnt >= TO_LIM);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (take_cfg || take_usr)       state_next = ST_ISSUE;
      ST_ISSUE:                                     state_next = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (!i_i2c_ready)               state_next = ST_WAIT_HIGH;
                    else if (start_to)              state_next = ST_ACK;
      ST_WAIT_HIGH: if (i_i2c_ready || busy_to)     state_next = ST_ACK;
      ST_ACK:                                       state_next = ST_GAP;
      ST_GAP:       if (cnt >= GAP_LIM)             state_next = ST_IDLE;
      default:                                      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_i2c_start = (state == ST_ISSUE);
    o_cfg_ack   = (state == ST_ACK) & o_grant[REQ_CFG];
    o_usr_ack   = (state == ST_ACK) & o_grant[REQ_USR];
    o_busy      = (state != ST_IDLE);
  end

  // Every state change restarts the shared counter, so each wait measures
  // time spent in its own state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                  cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else if (cnt != CNT_MAX)      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_i2c_addr <= 8'h00;
      o_i2c_data <= 8'h00;
      o_grant    <= 2'b00;
      o_err      <= 1'b0;
    end else begin
      if (state == ST_IDLE && take_cfg) begin
        o_i2c_addr <= i_cfg_addr;
        o_i2c_data <= i_cfg_data;
        o_grant    <= 2'b01;
      end else if (state == ST_IDLE && take_usr) begin
        o_i2c_addr <= i_usr_addr;
        o_i2c_data <= i_usr_data;
        o_grant    <= 2'b10;
      end else if (state == ST_ACK) begin
        o_grant    <= 2'b00;
      end
      if (start_to || busy_to) o_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter: scoreboard of expected grants plus a
// simple master model that answers start pulses.
`default_nettype none

module tb_sccb_arbiter;

  localparam int GAP = 100;
  localparam int SW  = 8;

  typedef struct packed {
    logic [1:0] grant;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk, rstn;
  logic       cfg_req, usr_req, cfg_done, i2c_ready;
  logic [7:0] cfg_addr, cfg_data, usr_addr, usr_data;
  logic       cfg_ack, usr_ack, i2c_start, busy, err;
  logic [7:0] i2c_addr, i2c_data;
  logic [1:0] grant;

  int   checks = 0, failures = 0, cyc = 0;
  int   start_cnt = 0, cfg_ack_cnt = 0, usr_ack_cnt = 0;
  int   m_mode = 0, m_cnt = 0, fall_cyc = 0, rise_cyc = 0;
  logic m_act = 0, m_kill = 0;
  txn_t exp_q[$];

  sccb_arbiter #(
    .CLK_F(100_000_000), .TIMEOUT_US(1), .START_WAIT(SW), .GAP_CYCLES(GAP)
  ) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_cfg_req(cfg_req), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .o_cfg_ack(cfg_ack), .i_cfg_done(cfg_done),
    .i_usr_req(usr_req), .i_usr_addr(usr_addr), .i_usr_data(usr_data),
    .o_usr_ack(usr_ack), .i_i2c_ready(i2c_ready), .o_i2c_start(i2c_start),
    .o_i2c_addr(i2c_addr), .o_i2c_data(i2c_data), .o_grant(grant),
    .o_busy(busy), .o_err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Master: mode 0 drops ready 2 cycles after start and raises it at +50,
  // mode 1 never raises it again, mode 2 ignores the start entirely.
  initial forever begin
    @(negedge clk);
    if (m_kill) begin
      i2c_ready = 1'b1;
      m_act     = 1'b0;
      m_kill    = 1'b0;
    end else if (i2c_start && m_mode != 2) begin
      m_act = 1'b1;
      m_cnt = 0;
    end else if (m_act) begin
      m_cnt++;
      if (m_cnt == 2) begin
        i2c_ready = 1'b0;
        fall_cyc  = cyc;
      end
      if (m_cnt == 50 && m_mode == 0) begin
        i2c_ready = 1'b1;
        rise_cyc  = cyc;
        m_act     = 1'b0;
      end
    end
  end

  // Scoreboard: each start pulse must match the next expected grant.
  initial forever begin
    @(negedge clk);
    if (i2c_start) begin
      start_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_start", exp_q.size(), 1);
      else begin
        txn_t e;
        e = exp_q.pop_front();
        chk("sb_grant", grant, e.grant);
        chk("sb_addr", i2c_addr, e.addr);
        chk("sb_data", i2c_data, e.data);
      end
    end
    if (cfg_ack) cfg_ack_cnt++;
    if (usr_ack) usr_ack_cnt++;
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return i2c_start;
      1:       return cfg_ack;
      2:       return usr_ack;
      3:       return err;
      default: return ~busy;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int bound, input string tag, output int at);
    logic ok;
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (sig(sel)) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    chk({tag, "_seen"}, {31'd0, ok}, 1);
  endtask

  task automatic push(input logic [1:0] g, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.grant = g;
    t.addr  = a;
    t.data  = d;
    exp_q.push_back(t);
  endtask

  initial begin
    int t0, t1, t2, n_cfg, n_usr, n_start;
    rstn = 1'b0; cfg_req = 1'b0; usr_req = 1'b0; cfg_done = 1'b0; i2c_ready = 1'b1;
    cfg_addr = 8'h00; cfg_data = 8'h00; usr_addr = 8'h00; usr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {9'd0, cfg_ack, usr_ack, i2c_start, i2c_addr, i2c_data, grant, busy, err}, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_not_busy", busy, 0);

    // Basic CFG write
    cfg_addr = 8'h12; cfg_data = 8'h80; cfg_req = 1'b1; t0 = cyc;
    push(2'b01, 8'h12, 8'h80);
    wait_until(0, 4, "cfg1_start", t1);
    chk("cfg1_start_latency", t1 - t0, 1);
    cfg_addr = 8'h55;
    @(negedge clk);
    chk("cfg1_start_width", i2c_start, 0);
    wait_until(1, 100, "cfg1_ack", t2);
    chk("cfg1_ack_after_ready", t2 - rise_cyc, 1);
    chk("cfg1_addr_ignored_change", i2c_addr, 8'h12);
    cfg_req = 1'b0;
    @(negedge clk);
    chk("cfg1_ack_width", cfg_ack, 0);
    chk("cfg1_grant_clear", grant, 0);
    // Ack cycle, GAP cycles of gap, one IDLE grant cycle, then the start.
    cfg_addr = 8'h34; cfg_data = 8'h01; cfg_req = 1'b1;
    push(2'b01, 8'h34, 8'h01);
    repeat (5) @(negedge clk);
    chk("addr_hold_in_gap", i2c_addr, 8'h12);
    wait_until(0, 200, "cfg2_start", t1);
    chk("gap_to_next_start", t1 - t2, GAP + 2);
    wait_until(1, 100, "cfg2_ack", t2);
    cfg_req = 1'b0;

    // USR held off until configuration is complete
    usr_addr = 8'h10; usr_data = 8'h40; usr_req = 1'b1;
    push(2'b10, 8'h10, 8'h40);
    n_start = start_cnt; n_usr = usr_ack_cnt;
    repeat (500) @(negedge clk);
    chk("usr_blocked_no_start", start_cnt, n_start);
    cfg_done = 1'b1; t0 = cyc;
    wait_until(0, 4, "usr_start", t1);
    chk("usr_start_latency", t1 - t0, 1);
    wait_until(2, 100, "usr_ack", t2);
    usr_req = 1'b0;
    @(negedge clk);
    chk("usr_ack_once", usr_ack_cnt - n_usr, 1);

    // Simultaneous requests: CFG first, then USR
    wait_until(4, 300, "idle_before_simul", t0);
    n_cfg = cfg_ack_cnt; n_usr = usr_ack_cnt;
    cfg_addr = 8'h20; cfg_data = 8'h21; usr_addr = 8'h30; usr_data = 8'h31;
    cfg_req = 1'b1; usr_req = 1'b1;
    push(2'b01, 8'h20, 8'h21);
    push(2'b10, 8'h30, 8'h31);
    wait_until(1, 100, "simul_cfg_ack", t1);
    cfg_req = 1'b0;
    wait_until(2, 300, "simul_usr_ack", t2);
    usr_req = 1'b0;
    @(negedge clk);
    chk("simul_cfg_acks", cfg_ack_cnt - n_cfg, 1);
    chk("simul_usr_acks", usr_ack_cnt - n_usr, 1);

    // Master never returns ready: busy watchdog
    wait_until(4, 300, "idle_before_to", t0);
    m_mode = 1;
    cfg_addr = 8'h40; cfg_data = 8'h41; cfg_req = 1'b1;
    push(2'b01, 8'h40, 8'h41);
    wait_until(3, 300, "to_err", t1);
    chk("to_err_window", {31'd0, (t1 - fall_cyc >= 100) && (t1 - fall_cyc <= 102)}, 1);
    chk("to_ack_with_err", cfg_ack, 1);
    cfg_req = 1'b0; m_kill = 1'b1; m_mode = 0;
    wait_until(4, 300, "idle_after_to", t0);
    usr_addr = 8'h44; usr_data = 8'h45; usr_req = 1'b1;
    push(2'b10, 8'h44, 8'h45);
    wait_until(2, 100, "post_to_usr_ack", t2);
    chk("post_to_ack_after_ready", t2 - rise_cyc, 1);
    chk("err_sticky", err, 1);
    usr_req = 1'b0;

    // Reset in the middle of WAIT_HIGH
    wait_until(4, 300, "idle_before_rst", t0);
    cfg_addr = 8'h50; cfg_data = 8'h51; cfg_req = 1'b1;
    push(2'b01, 8'h50, 8'h51);
    wait_until(0, 4, "rst_start", t1);
    repeat (10) @(negedge clk);
    n_cfg = cfg_ack_cnt;
    rstn = 1'b0; m_kill = 1'b1;
    #1;
    chk("rst_async_outputs", {9'd0, cfg_ack, usr_ack, i2c_start, i2c_addr, i2c_data, grant, busy, err}, 0);
    repeat (3) @(negedge clk);
    chk("rst_no_ack", cfg_ack_cnt, n_cfg);
    push(2'b01, 8'h50, 8'h51);
    rstn = 1'b1; t0 = cyc;
    wait_until(0, 4, "rst_regrant_start", t1);
    chk("rst_regrant_latency", t1 - t0, 1);
    wait_until(1, 100, "rst_regrant_ack", t2);
    cfg_req = 1'b0;

    // Master ignores the start: start watchdog
    wait_until(4, 300, "idle_before_sw", t0);
    m_mode = 2;
    cfg_addr = 8'h60; cfg_data = 8'h61; cfg_req = 1'b1;
    push(2'b01, 8'h60, 8'h61);
    wait_until(0, 4, "sw_start", t1);
    repeat (SW) @(negedge clk);
    chk("sw_err_not_early", err, 0);
    wait_until(3, 10, "sw_err", t2);
    chk("sw_err_window", {31'd0, (t2 - t1 > SW) && (t2 - t1 <= SW + 3)}, 1);
    chk("sw_ack_with_err", cfg_ack, 1);
    cfg_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sccb_arbiter.md
Name: sccb_arbiter

Overview:
- Shares the single SCCB/I2C write master between two requesters:
  - the power-up configuration sequencer (requester 0, CFG);
  - the runtime register-tweak path (requester 1, USR), used for exposure and brightness changes from switches.
- Grants one write at a time and pulses the master's start input.
- Tracks the master through busy and back to ready, then acknowledges the requester.
- Enforces a bus-free gap between transactions and a timeout watchdog.

Parameters:
- CLK_F, 100_000_000, i_clk frequency in Hz.
- TIMEOUT_US, 1000, max time in µs from start until the master returns ready. Derives TIMEOUT_CYCLES = CLK_F/1_000_000*TIMEOUT_US.
- START_WAIT, 8, max cycles after the start pulse for i_i2c_ready to fall.
- GAP_CYCLES, 100, idle cycles enforced after each ack before the next grant.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_cfg_req  in  1  CFG request, level; held until o_cfg_ack
- i_cfg_addr  in  8  CFG register address
- i_cfg_data  in  8  CFG register data
- o_cfg_ack  out  1  one-cycle pulse: CFG write finished
- i_cfg_done  in  1  configuration complete; enables USR
- i_usr_req  in  1  USR request, level; held until o_usr_ack
- i_usr_addr  in  8  USR register address
- i_usr_data  in  8  USR register data
- o_usr_ack  out  1  one-cycle pulse: USR write finished
- i_i2c_ready  in  1  master idle/ready
- o_i2c_start  out  1  one-cycle start pulse to the master
- o_i2c_addr  out  8  register address to the master
- o_i2c_data  out  8  register data to the master
- o_grant  out  2  one-hot current owner: bit0 CFG, bit1 USR
- o_busy  out  1  high in any state other than IDLE
- o_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, i_rstn=0): every output is 0 and the state is IDLE. Reset mid-transaction abandons the write and drops any pending ack.
- Clock and reset are i_clk and i_rstn as listed in Ports.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ACK, GAP.
- IDLE, grant rules:
  - Grant requires i_i2c_ready=1.
  - If i_cfg_req=1, grant CFG.
  - Else if i_usr_req=1 and i_cfg_done=1, grant USR.
  - CFG has fixed priority. USR requests before i_cfg_done stay pending and are never dropped.
- IDLE, on grant:
  - Capture the owner's addr/data into o_i2c_addr/o_i2c_data.
  - Set o_grant.
  - Go to ISSUE.
- ISSUE:
  - o_i2c_start=1 for exactly this cycle.
  - Clear the counter and go to WAIT_LOW.
- WAIT_LOW:
  - If i_i2c_ready=0, go to WAIT_HIGH.
  - If the counter reaches START_WAIT with ready still 1, set o_err and go to ACK. The master did not accept the start, but the requester is not hung.
- WAIT_HIGH:
  - If i_i2c_ready=1, go to ACK.
  - If the counter reaches TIMEOUT_CYCLES, set o_err and go to ACK.
- ACK:
  - Pulse the owner's ack for 1 cycle.
  - Clear o_grant and go to GAP.
- GAP:
  - Count GAP_CYCLES, then go to IDLE.
  - Requesters see ack and must drop req within GAP_CYCLES. A req still high at IDLE is a new request.
- Latency: a grant in IDLE in cycle N puts the start pulse in N+1. The ack comes 1 cycle after ready returns high.
- o_i2c_addr/o_i2c_data are stable from grant until the next grant; they hold their value in IDLE.
- Address/data changes on a requester while it is granted are ignored (already captured).
- Simultaneous CFG and USR requests at IDLE: CFG wins and USR waits for the next IDLE.
- A single shared counter serves WAIT_LOW, WAIT_HIGH and GAP. It is sized by $clog2(max(TIMEOUT_CYCLES, GAP_CYCLES, START_WAIT)+1) and saturates; it never wraps.
- o_err clears only on reset.

Decomposition:
- Package sccb_pkg holds:
  - state enum sccb_arb_state_t;
  - requester index constants REQ_CFG=0 and REQ_USR=1;
  - the TIMEOUT_CYCLES derivation function.
- No sub-module. The counter is inline because it is shared across states.

Test Plan:
- CFG write, addr 0x12 data 0x80; master model drops ready at +2 and raises it at +50:
  - o_i2c_start high exactly 1 cycle, the cycle after grant, with addr/data = 0x12/0x80;
  - o_cfg_ack pulses 1 cycle after ready rises;
  - next grant no earlier than GAP_CYCLES after the ack.
- USR req (0x10/0x40) with i_cfg_done=0 for 500 cycles: no start is issued. Raise i_cfg_done: a grant follows within 1 cycle and o_usr_ack arrives later.
- CFG and USR asserted in the same cycle with i_cfg_done=1: CFG is served first (o_grant=01) and USR next (o_grant=10); exactly one ack each.
- Master never raises ready after the start (TIMEOUT_US=1, CLK_F=100e6):
  - o_err sets at 100 cycles in WAIT_HIGH and the ack still pulses;
  - a following transaction completes normally while o_err stays 1.
- Master ignores start (ready stays 1): o_err is set after START_WAIT=8 cycles, then the ack pulses.
- i_rstn asserted during WAIT_HIGH: all outputs 0 immediately with no ack. After release, a held CFG req is re-granted with a fresh start pulse.
